muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// resolving UNROLL bits per CALC cycle, with sign fix-up and special cases applied in FIX.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int K  = WIDTH / UNROLL;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2:0]           op_q, op_d;
  logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       shifted, diff, sum;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, fix_result;

  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed & operand_a[WIDTH-1];
  assign b_neg    = b_signed & operand_b[WIDTH-1];
  assign a_mag    = a_neg ? -operand_a : operand_a;
  assign b_mag    = b_neg ? -operand_b : operand_b;

  // acc holds {high product, multiplier} when multiplying and {remainder, quotient} when dividing
  always_comb begin
    acc_step = acc_q;
    shifted  = '0;
    diff     = '0;
    sum      = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        shifted = acc_step[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd_q};
        if (!diff[WIDTH]) acc_step = {diff[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b1};
        else              acc_step = {shifted[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b0};
      end else begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, opnd_q} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod       = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo        = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];
    fix_result = '0;
    if (!op_q[2])      fix_result = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else if (!op_q[1]) fix_result = div_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quo : quo);
    else               fix_result = sign_a_q ? -rem : rem;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d       = funct3;
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          div_zero_d = (operand_b == '0);
          opnd_d     = funct3[2] ? b_mag : a_mag;
          acc_d      = funct3[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abort must leave the previously delivered result untouched
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q       <= op_d;
    sign_a_q   <= sign_a_d;
    sign_b_q   <= sign_b_d;
    div_zero_q <= div_zero_d;
    opnd_q     <= opnd_d;
    acc_q      <= acc_d;
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases on WIDTH=32/UNROLL=1 plus a
// random sweep over WIDTH {8,32,64} x UNROLL {1,2,4} against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int NCFG = 9;
  localparam int MAIN = 3;

  logic             clock;
  logic             reset;
  logic [NCFG-1:0]  start_v, flush_v, busy_v, done_v;
  logic [2:0]       funct3;
  logic [63:0]      operand_a, operand_b;
  logic [63:0]      result_v [NCFG];
  int               checks, errors;

  // Configuration g: WIDTH = 8/32/64 for g/3 = 0/1/2, UNROLL = 1/2/4 for g%3 = 0/1/2
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = (g < 3) ? 8 : (g < 6) ? 32 : 64;
    localparam int U = 1 << (g % 3);
    logic [W-1:0] res;
    muldiv_unit #(.WIDTH(W), .UNROLL(U)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start_v[g]),
      .flush     (flush_v[g]),
      .funct3    (funct3),
      .operand_a (operand_a[W-1:0]),
      .operand_b (operand_b[W-1:0]),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .result    (res)
    );
    assign result_v[g] = 64'(res);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int w_of(input int g);
    return (g < 3) ? 8 : (g < 6) ? 32 : 64;
  endfunction

  function automatic int k_of(input int g);
    return w_of(g) / (1 << (g % 3));
  endfunction

  // Reference: interpret operands as mathematical integers and apply the RISC-V M rules
  function automatic logic [63:0] ref_model(input int w, input logic [2:0] f,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0]         mask, a, b;
    logic signed [131:0] two_w, sa, sb, ua, ub, p, q;
    mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    a     = a_in & mask;
    b     = b_in & mask;
    two_w = 132'sd1 <<< w;
    ua    = $signed({68'd0, a});
    ub    = $signed({68'd0, b});
    sa    = a[w-1] ? ua - two_w : ua;
    sb    = b[w-1] ? ub - two_w : ub;
    case (f)
      3'b000: begin p = sa * sb; return p[63:0] & mask; end
      3'b001: begin p = sa * sb; q = p >>> w; return q[63:0] & mask; end
      3'b010: begin p = sa * ub; q = p >>> w; return q[63:0] & mask; end
      3'b011: begin p = ua * ub; q = p >>> w; return q[63:0] & mask; end
      3'b100: begin
        if (b == 64'd0) return mask;
        if (sa == -(two_w >>> 1) && sb == -132'sd1) return a;
        q = sa / sb; return q[63:0] & mask;
      end
      3'b101: begin
        if (b == 64'd0) return mask;
        q = ua / ub; return q[63:0] & mask;
      end
      3'b110: begin
        if (b == 64'd0) return a;
        if (sa == -(two_w >>> 1) && sb == -132'sd1) return 64'd0;
        q = sa % sb; return q[63:0] & mask;
      end
      default: begin
        if (b == 64'd0) return a;
        q = ua % ub; return q[63:0] & mask;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int g);
    int guard = 0;
    while (busy_v[g] && guard < 400) begin
      @(posedge clock); #1;
      guard++;
    end
    if (busy_v[g]) checkOutput("idle_timeout", 64'(busy_v[g]), 64'd0);
  endtask

  // Issue one operation; lat counts edges from the accept edge (inclusive) to done
  task automatic applyStimulus(input int g, input logic [2:0] f, input logic [63:0] a,
                               input logic [63:0] b, output logic [63:0] res, output int lat);
    wait_idle(g);
    funct3     = f;
    operand_a  = a;
    operand_b  = b;
    start_v[g] = 1'b1;
    @(posedge clock); #1;
    start_v[g] = 1'b0;
    operand_a  = {$urandom(), $urandom()};
    operand_b  = {$urandom(), $urandom()};
    lat = 1;
    res = '0;
    while (!done_v[g] && lat < 300) begin
      @(posedge clock); #1;
      lat++;
    end
    if (done_v[g]) res = result_v[g];
    else           lat = -1;
  endtask

  task automatic do_op(input int g, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input string tag);
    logic [63:0] res;
    int          lat;
    applyStimulus(g, f, a, b, res, lat);
    checkOutput(tag, res, exp);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(k_of(g) + 2));
  endtask

  initial begin
    logic [63:0] a0, b0, exp, got, prior;
    int          ndone, first_done, km;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start_v   = '0;
    flush_v   = '0;
    funct3    = 3'b000;
    operand_a = '0;
    operand_b = '0;
    km        = k_of(MAIN);
    repeat (3) @(posedge clock);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checkOutput($sformatf("reset_busy_g%0d", g), 64'(busy_v[g]), 64'd0);
      checkOutput($sformatf("reset_done_g%0d", g), 64'(done_v[g]), 64'd0);
      checkOutput($sformatf("reset_result_g%0d", g), result_v[g], 64'd0);
    end
    reset = 1'b0;
    @(posedge clock); #1;

    // All-ones multiplies
    do_op(MAIN, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0001, "mul_ones");
    do_op(MAIN, 3'b001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0000, "mulh_ones");
    do_op(MAIN, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulhsu_ones");
    do_op(MAIN, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "mulhu_ones");

    // Signed/unsigned divide of -7 by 2
    do_op(MAIN, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, "div_m7");
    do_op(MAIN, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, "rem_m7");
    do_op(MAIN, 3'b101, 64'hFFFF_FFF9, 64'd2, 64'h7FFF_FFFC, "divu_m7");
    do_op(MAIN, 3'b111, 64'hFFFF_FFF9, 64'd2, 64'h0000_0001, "remu_m7");

    // Divide by zero and signed overflow
    do_op(MAIN, 3'b100, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF, "div_zero");
    do_op(MAIN, 3'b101, 64'h1234_5678, 64'd0, 64'hFFFF_FFFF, "divu_zero");
    do_op(MAIN, 3'b110, 64'h1234_5678, 64'd0, 64'h1234_5678, "rem_zero");
    do_op(MAIN, 3'b111, 64'h1234_5678, 64'd0, 64'h1234_5678, "remu_zero");
    do_op(MAIN, 3'b100, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFFF, "div_neg_zero");
    do_op(MAIN, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "div_ovf");
    do_op(MAIN, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0000_0000, "rem_ovf");

    // start held high with changing operands: only the first request counts
    wait_idle(MAIN);
    a0 = 64'h0000_1234;
    b0 = 64'h0000_0056;
    exp = ref_model(32, 3'b000, a0, b0);
    funct3        = 3'b000;
    operand_a     = a0;
    operand_b     = b0;
    start_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    ndone = 0;
    first_done = -1;
    got = '0;
    for (int m = 1; m <= km + 1; m++) begin
      operand_a = {$urandom(), $urandom()};
      operand_b = {$urandom(), $urandom()};
      funct3    = 3'($urandom());
      @(posedge clock); #1;
      if (done_v[MAIN]) begin
        ndone++;
        got = result_v[MAIN];
        if (first_done < 0) first_done = m;
      end
    end
    checkOutput("b2b_done_count", 64'(ndone), 64'd1);
    checkOutput("b2b_done_edge", 64'(first_done), 64'(km + 1));
    checkOutput("b2b_result", got, exp);
    @(posedge clock); #1;
    checkOutput("b2b_idle_gap", 64'(busy_v[MAIN]), 64'd0);
    @(posedge clock); #1;
    checkOutput("b2b_reaccept", 64'(busy_v[MAIN]), 64'd1);
    start_v[MAIN] = 1'b0;
    flush_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    flush_v[MAIN] = 1'b0;
    checkOutput("b2b_flushed", 64'(busy_v[MAIN]), 64'd0);

    // Flush in the middle of CALC
    do_op(MAIN, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "pre_flush");
    prior = 64'hFFFF_FFFE;
    wait_idle(MAIN);
    funct3        = 3'b000;
    operand_a     = 64'd3;
    operand_b     = 64'd5;
    start_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    start_v[MAIN] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    flush_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    flush_v[MAIN] = 1'b0;
    checkOutput("flush_busy", 64'(busy_v[MAIN]), 64'd0);
    ndone = 0;
    repeat (km + 5) begin
      @(posedge clock); #1;
      if (done_v[MAIN]) ndone++;
    end
    checkOutput("flush_no_done", 64'(ndone), 64'd0);
    checkOutput("flush_result_kept", result_v[MAIN], prior);
    do_op(MAIN, 3'b000, 64'd3, 64'd5, 64'd15, "post_flush");

    // flush together with start in IDLE drops the request
    start_v[MAIN] = 1'b1;
    flush_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    start_v[MAIN] = 1'b0;
    flush_v[MAIN] = 1'b0;
    checkOutput("flush_start_idle", 64'(busy_v[MAIN]), 64'd0);

    // Random sweep over all configurations and all operations
    for (int g = 0; g < NCFG; g++) begin
      for (int f = 0; f < 8; f++) begin
        for (int r = 0; r < 2; r++) begin
          a0 = {$urandom(), $urandom()};
          b0 = {$urandom(), $urandom()};
          case ($urandom_range(0, 5))
            0: b0 = 64'd0;
            1: begin a0 = 64'd1 << (w_of(g) - 1); b0 = 64'hFFFF_FFFF_FFFF_FFFF; end
            default: ;
          endcase
          exp = ref_model(w_of(g), 3'(f), a0, b0);
          do_op(g, 3'(f), a0, b0, exp, $sformatf("sweep_g%0d_f%0d", g, f));
        end
      end
    end

    // Synchronous reset in the middle of CALC clears the result
    do_op(MAIN, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, "pre_reset");
    wait_idle(MAIN);
    funct3        = 3'b001;
    operand_a     = 64'd5;
    operand_b     = 64'd7;
    start_v[MAIN] = 1'b1;
    @(posedge clock); #1;
    start_v[MAIN] = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("midreset_busy", 64'(busy_v[MAIN]), 64'd0);
    checkOutput("midreset_done", 64'(done_v[MAIN]), 64'd0);
    checkOutput("midreset_result", result_v[MAIN], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
